// File: rtl/sd_resp_rx_chk.sv
// SD command-response receiver with on-the-fly CRC7, frame, index and NCR checks.
// Ports: ex_clk/reset, sd_clk_en strobe, start/resp_type/expected_idx in; sd_cmd serial in;
//        busy, done pulse, response[127:0], crc_err, frame_err, idx_err, timeout_err out.
module sd_resp_rx_chk #(
  parameter int NCR_MAX = 64,
  parameter int CNT_W   = 8
) (
  input  logic         ex_clk,
  input  logic         reset,
  input  logic         sd_clk_en,
  input  logic         start,
  input  logic [1:0]   resp_type,
  input  logic [5:0]   expected_idx,
  input  logic         sd_cmd,
  output logic         busy,
  output logic         done,
  output logic [127:0] response,
  output logic         crc_err,
  output logic         frame_err,
  output logic         idx_err,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECV,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] NCR_LAST = CNT_W'(NCR_MAX - 1);
  localparam logic [CNT_W-1:0] LAST_S   = CNT_W'(47);
  localparam logic [CNT_W-1:0] LAST_L   = CNT_W'(135);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       crc;
  logic [133:0]     sr;
  logic [1:0]       rtype;
  logic [5:0]       idx;

  logic             is_long;
  logic [CNT_W-1:0] last_cnt;
  logic [134:0]     frame_nx;
  logic             crc_on;
  logic [6:0]       crc_nx;
  logic             fb;
  logic             unused_bits;

  // frame_nx is the frame as it stands once this strobe's bit is in;
  // at the end bit it is the whole frame minus the start bit.
  always_comb begin
    is_long  = (rtype == 2'b10);
    last_cnt = is_long ? LAST_L : LAST_S;
    frame_nx = {sr, sd_cmd};
    // cnt is the position of the current bit counted from the start bit
    crc_on   = is_long ? (cnt >= CNT_W'(8) && cnt < CNT_W'(128))
                       : (cnt < CNT_W'(40));
    fb       = sd_cmd ^ crc[6];
    crc_nx   = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  end

  assign unused_bits = ^frame_nx[133:128];
  assign busy        = (state != IDLE);

  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      crc         <= '0;
      sr          <= '0;
      rtype       <= '0;
      idx         <= '0;
      done        <= 1'b0;
      response    <= '0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
      idx_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            crc         <= '0;
            sr          <= '0;
            rtype       <= resp_type;
            idx         <= expected_idx;
            response    <= '0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            idx_err     <= 1'b0;
            timeout_err <= 1'b0;
            if (resp_type == 2'b00) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT_START;
            end
          end
        end
        WAIT_START: begin
          if (sd_clk_en) begin
            if (!sd_cmd) begin
              // start bit: a 0 into a zero CRC leaves it zero,
              // so crc needs no update for short or long frames
              sr    <= {sr[132:0], 1'b0};
              cnt   <= CNT_W'(1);
              state <= RECV;
            end else if (cnt == NCR_LAST) begin
              timeout_err <= 1'b1;
              state       <= DONE;
              done        <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RECV: begin
          if (sd_clk_en) begin
            sr  <= frame_nx[133:0];
            cnt <= cnt + 1'b1;
            if (crc_on) crc <= crc_nx;
            if (cnt == last_cnt) begin
              state <= DONE;
              done  <= 1'b1;
              if (is_long) begin
                response  <= {1'b0, frame_nx[127:1]};
                frame_err <= frame_nx[134] | ~frame_nx[0];
              end else begin
                response  <= {90'b0, frame_nx[45:8]};
                frame_err <= frame_nx[46] | ~frame_nx[0];
              end
              crc_err <= (rtype != 2'b11) && (crc != frame_nx[7:1]);
              idx_err <= (rtype == 2'b01) && (frame_nx[45:40] != idx);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_resp_rx_chk.sv
// Randomised self-checking bench for sd_resp_rx_chk.
// Reference model works on whole frames: CRC by polynomial long division.
module tb_sd_resp_rx_chk;

  logic         ex_clk = 1'b0;
  logic         reset;
  logic         sd_clk_en;
  logic         start;
  logic [1:0]   resp_type;
  logic [5:0]   expected_idx;
  logic         sd_cmd;
  logic         busy;
  logic         done;
  logic [127:0] response;
  logic         crc_err;
  logic         frame_err;
  logic         idx_err;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;
  int dcnt   = 0;

  sd_resp_rx_chk #(.NCR_MAX(64), .CNT_W(8)) dut (
    .ex_clk       (ex_clk),
    .reset        (reset),
    .sd_clk_en    (sd_clk_en),
    .start        (start),
    .resp_type    (resp_type),
    .expected_idx (expected_idx),
    .sd_cmd       (sd_cmd),
    .busy         (busy),
    .done         (done),
    .response     (response),
    .crc_err      (crc_err),
    .frame_err    (frame_err),
    .idx_err      (idx_err),
    .timeout_err  (timeout_err)
  );

  always #5 ex_clk = ~ex_clk;

  always @(posedge ex_clk) if (done) dcnt++;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // remainder of M(x)*x^7 mod x^7+x^3+1, M = f[hi:lo]
  function automatic logic [6:0] crc_ref(input logic [135:0] f,
                                         input int hi, input int lo);
    logic [142:0] m;
    m = '0;
    for (int i = hi; i >= lo; i--) m = {m[141:0], f[i]};
    m = m << 7;
    for (int j = 142; j >= 7; j--)
      if (m[j]) m[j -: 8] = m[j -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      @(negedge ex_clk);
      sd_clk_en = 1'b0;
    end
    @(negedge ex_clk);
    sd_clk_en = 1'b1;
    sd_cmd    = b;
  endtask

  task automatic do_start(input logic [1:0] t, input logic [5:0] ix);
    @(negedge ex_clk);
    sd_clk_en    = 1'b0;
    sd_cmd       = 1'b1;
    start        = 1'b1;
    resp_type    = t;
    expected_idx = ix;
    @(negedge ex_clk);
    start = 1'b0;
  endtask

  // mode 0 normal, 1 stray start mid-frame, 2 reset after bit 20
  task automatic run_frame(input logic [1:0] t, input logic [5:0] ix,
                           input logic [135:0] f, input int gap,
                           input int pre, input int mode);
    int L;
    int d0;
    logic [127:0] er;
    logic ec, ef, ei;
    L = (t == 2'b10) ? 136 : 48;
    if (L == 136) begin
      er = {1'b0, f[127:1]};
      ec = crc_ref(f, 127, 8) != f[7:1];
      ef = f[134] | ~f[0];
      ei = 1'b0;
    end else begin
      er = {90'b0, f[45:8]};
      ec = (t == 2'b01) && (crc_ref(f, 47, 8) != f[7:1]);
      ef = f[46] | ~f[0];
      ei = (t == 2'b01) && (f[45:40] != ix);
    end
    do_start(t, ix);
    d0 = dcnt;
    repeat (pre) send_bit(1'b1, gap);
    for (int k = 0; k < L; k++) begin
      send_bit(f[L-1-k], gap);
      if (mode == 1 && k == 10) begin
        start     = 1'b1;
        resp_type = 2'b00;
        @(negedge ex_clk);
        start     = 1'b0;
        sd_clk_en = 1'b0;
      end
      if (mode == 2 && k == 20) begin
        @(negedge ex_clk);
        sd_clk_en = 1'b0;
        reset     = 1'b1;
        @(negedge ex_clk);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_resp", response, 128'd0);
        chk("rst_flags", 128'({crc_err, frame_err, idx_err, timeout_err}),
            128'd0);
        reset = 1'b0;
        repeat (5) @(negedge ex_clk);
        chk("rst_nodone", 128'(dcnt - d0), 128'd0);
        return;
      end
    end
    @(negedge ex_clk);
    sd_clk_en = 1'b0;
    chk("done_lat", 128'(done), 128'd1);
    chk("resp", response, er);
    chk("crc_err", 128'(crc_err), 128'(ec));
    chk("frame_err", 128'(frame_err), 128'(ef));
    chk("idx_err", 128'(idx_err), 128'(ei));
    chk("timeout", 128'(timeout_err), 128'd0);
    repeat (3) @(negedge ex_clk);
    chk("done_once", 128'(dcnt - d0), 128'd1);
    chk("idle", 128'(busy), 128'd0);
  endtask

  function automatic logic [135:0] mk_frame(input logic [1:0] t,
                                            input logic [5:0] ix);
    logic [135:0] f;
    f = '0;
    if (t == 2'b10) begin
      f[133:128] = 6'h3F;
      f[127:8]   = {$urandom, $urandom, $urandom, $urandom};
      f[7:1]     = crc_ref(f, 127, 8);
      f[0]       = 1'b1;
    end else begin
      f[45:40] = ix;
      f[39:8]  = $urandom;
      f[7:1]   = (t == 2'b11) ? 7'h7F : crc_ref(f, 47, 8);
      f[0]     = 1'b1;
    end
    return f;
  endfunction

  logic [135:0] fr;
  logic [1:0]   rt;
  logic [5:0]   rix;
  int           d0;
  int           L;

  initial begin
    reset        = 1'b1;
    sd_clk_en    = 1'b0;
    start        = 1'b0;
    resp_type    = 2'b00;
    expected_idx = 6'd0;
    sd_cmd       = 1'b1;
    repeat (3) @(negedge ex_clk);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_resp", response, 128'd0);
    chk("reset_flags", 128'({crc_err, frame_err, idx_err, timeout_err}),
        128'd0);
    reset = 1'b0;

    // R7 directed vectors
    fr = {88'b0, 48'h08_00_00_01_AA_13};
    run_frame(2'b01, 6'd8, fr, 3, 2, 0);
    chk("r7_resp", response, 128'h08_000001AA);
    chk("r7_flags", 128'({crc_err, frame_err, idx_err, timeout_err}), 128'd0);
    fr[7:0] = 8'h15;
    run_frame(2'b01, 6'd8, fr, 3, 0, 0);
    chk("r7_bad_crc", 128'({crc_err, frame_err, idx_err}), 128'b100);
    fr[7:0] = 8'h13;
    run_frame(2'b01, 6'd9, fr, 3, 1, 0);
    chk("r7_bad_idx", 128'({crc_err, frame_err, idx_err}), 128'b001);
    fr[7:0] = 8'h12;
    run_frame(2'b01, 6'd8, fr, 3, 0, 0);
    chk("r7_bad_end", 128'({crc_err, frame_err, idx_err}), 128'b010);
    fr[7:0] = 8'h13;
    run_frame(2'b01, 6'd8, fr, 0, 0, 0);
    chk("r7_tied_en", 128'({crc_err, frame_err, idx_err}), 128'b000);

    // R3
    fr = {88'b0, 48'h3F_80_FF_80_00_FF};
    run_frame(2'b11, 6'd3, fr, 2, 1, 0);
    chk("r3_resp", response, {90'b0, 6'h3F, 32'h80FF8000});
    chk("r3_flags", 128'({crc_err, idx_err}), 128'd0);

    // R2
    fr = '0;
    fr[135:128] = 8'h3F;
    fr[0] = 1'b1;
    run_frame(2'b10, 6'd0, fr, 1, 0, 0);
    chk("r2_zero", 128'({crc_err, frame_err, idx_err}), 128'd0);
    fr[64] = 1'b1;
    run_frame(2'b10, 6'd0, fr, 1, 0, 0);
    chk("r2_flip", 128'(crc_err), 128'd1);

    // NCR timeout
    do_start(2'b01, 6'd1);
    d0 = dcnt;
    for (int s = 1; s <= 64; s++) begin
      send_bit(1'b1, 1);
      if (s == 64) chk("to_pre_done", 128'({busy, done}), 128'b10);
    end
    @(negedge ex_clk);
    sd_clk_en = 1'b0;
    chk("to_done", 128'(done), 128'd1);
    chk("to_err", 128'({timeout_err, crc_err, frame_err, idx_err}),
        128'b1000);
    repeat (2) @(negedge ex_clk);
    chk("to_once", 128'(dcnt - d0), 128'd1);

    // start bit on the 64th strobe
    fr = {88'b0, 48'h08_00_00_01_AA_13};
    run_frame(2'b01, 6'd8, fr, 1, 63, 0);

    // resp_type none
    do_start(2'b00, 6'd0);
    d0 = dcnt;
    for (int c = 0; c < 4 && dcnt == d0; c++) @(negedge ex_clk);
    chk("none_done", 128'(dcnt - d0), 128'd1);
    chk("none_flags", 128'({crc_err, frame_err, idx_err, timeout_err}),
        128'd0);

    // stray start while busy, then reset at bit 20
    run_frame(2'b01, 6'd8, fr, 2, 0, 1);
    run_frame(2'b01, 6'd8, fr, 2, 0, 2);

    // randomised frames
    for (int n = 0; n < 30; n++) begin
      rt  = 2'($urandom_range(1, 3));
      rix = 6'($urandom);
      fr  = mk_frame(rt, rix);
      L   = (rt == 2'b10) ? 136 : 48;
      if ($urandom_range(0, 2) == 0) fr[$urandom_range(0, L - 2)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) rix = rix ^ 6'd1;
      run_frame(rt, rix, fr, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 5)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
